// File: rtl/keypad_bcd_entry_if.sv
// Keypad and digit bus of the BCD keypad entry block.
// The master side is the keypad scanner; the slave side is the keypad plus
// whatever consumes the digits (display controller, testbench).
interface keypad_bcd_entry_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] uni;
  logic [3:0] dec;
  logic [3:0] cen;
  logic [3:0] mil;
  logic [3:0] key_code;
  logic       key_valid;

  modport master (
    input  row,
    output col, uni, dec, cen, mil, key_code, key_valid
  );

  modport slave (
    output row,
    input  col, uni, dec, cen, mil, key_code, key_valid
  );
endinterface

// File: rtl/keypad_bcd_entry.sv
// 4x4 matrix keypad scanner with debounce that edits a 4-digit BCD number.
// One column is driven low per scan slot; a single pressed key is confirmed
// over several scan ticks, reported once, and then must be released (also
// debounced) before scanning resumes.
module keypad_bcd_entry #(
  parameter int SCAN_DIV     = 100000,
  parameter int DEBOUNCE_CNT = 5
) (
  input logic                 clk,
  input logic                 rst,
  keypad_bcd_entry_if.master  bus
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CNT);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HOLD
  } state_t;

  state_t           state;
  logic [3:0]       row_meta;
  logic [3:0]       row_s;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [3:0]       col;
  logic [3:0]       cap_row;
  logic [1:0]       cap_r;
  logic [1:0]       cap_c;
  logic [DEB_W-1:0] deb_cnt;
  logic [DEB_W-1:0] deb_next;
  logic [3:0]       uni;
  logic [3:0]       dec;
  logic [3:0]       cen;
  logic [3:0]       mil;
  logic [3:0]       key_code;
  logic             key_valid;
  logic             single_low;
  logic [1:0]       row_idx;
  logic [1:0]       col_idx;
  logic [3:0]       key_lookup;
  logic [3:0]       col_rot;

  assign bus.col       = col;
  assign bus.uni       = uni;
  assign bus.dec       = dec;
  assign bus.cen       = cen;
  assign bus.mil       = mil;
  assign bus.key_code  = key_code;
  assign bus.key_valid = key_valid;

  assign tick     = (div_cnt == DIV_LAST);
  assign deb_next = deb_cnt + DEB_W'(1);
  assign col_rot  = {col[2:0], col[3]};

  // Two-flop synchronizer for the asynchronous, pulled-up row lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta <= 4'b1111;
      row_s    <= 4'b1111;
    end else begin
      row_meta <= bus.row;
      row_s    <= row_meta;
    end
  end

  // Scan-slot divider; the last count of each slot is the scan tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Which row / column is active: only a single low row is a usable press.
  always_comb begin
    single_low = 1'b0;
    row_idx    = 2'd0;
    col_idx    = 2'd0;
    case (row_s)
      4'b1110: begin single_low = 1'b1; row_idx = 2'd0; end
      4'b1101: begin single_low = 1'b1; row_idx = 2'd1; end
      4'b1011: begin single_low = 1'b1; row_idx = 2'd2; end
      4'b0111: begin single_low = 1'b1; row_idx = 2'd3; end
      default: begin single_low = 1'b0; row_idx = 2'd0; end
    endcase
    case (col)
      4'b1110: col_idx = 2'd0;
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
  end

  // Key code of the captured row/column; '*' reports E and '#' reports F.
  always_comb begin
    key_lookup = 4'h0;
    case ({cap_r, cap_c})
      4'h0: key_lookup = 4'h1;
      4'h1: key_lookup = 4'h2;
      4'h2: key_lookup = 4'h3;
      4'h3: key_lookup = 4'hA;
      4'h4: key_lookup = 4'h4;
      4'h5: key_lookup = 4'h5;
      4'h6: key_lookup = 4'h6;
      4'h7: key_lookup = 4'hB;
      4'h8: key_lookup = 4'h7;
      4'h9: key_lookup = 4'h8;
      4'hA: key_lookup = 4'h9;
      4'hB: key_lookup = 4'hC;
      4'hC: key_lookup = 4'hE;
      4'hD: key_lookup = 4'h0;
      4'hE: key_lookup = 4'hF;
      4'hF: key_lookup = 4'hD;
      default: key_lookup = 4'h0;
    endcase
  end

  // Scan/debounce/hold state machine with the digit register it edits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SCAN;
      col       <= 4'b1110;
      cap_row   <= 4'b1111;
      cap_r     <= 2'd0;
      cap_c     <= 2'd0;
      deb_cnt   <= '0;
      uni       <= 4'd0;
      dec       <= 4'd0;
      cen       <= 4'd0;
      mil       <= 4'd0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (tick) begin
        case (state)
          SCAN: begin
            if (single_low) begin
              cap_row <= row_s;
              cap_r   <= row_idx;
              cap_c   <= col_idx;
              deb_cnt <= DEB_W'(1);
              state   <= DEBOUNCE;
            end else begin
              col <= col_rot;
            end
          end
          DEBOUNCE: begin
            if (row_s == cap_row) begin
              if (deb_next == DEB_LAST) begin
                state     <= HOLD;
                deb_cnt   <= '0;
                key_valid <= 1'b1;
                key_code  <= key_lookup;
                if (key_lookup <= 4'd9) begin
                  mil <= cen;
                  cen <= dec;
                  dec <= uni;
                  uni <= key_lookup;
                end else if (key_lookup == 4'hE) begin
                  mil <= 4'd0;
                  cen <= 4'd0;
                  dec <= 4'd0;
                  uni <= 4'd0;
                end else if (key_lookup == 4'hF) begin
                  uni <= dec;
                  dec <= cen;
                  cen <= mil;
                  mil <= 4'd0;
                end
              end else begin
                deb_cnt <= deb_next;
              end
            end else begin
              state   <= SCAN;
              deb_cnt <= '0;
              col     <= col_rot;
            end
          end
          HOLD: begin
            if (row_s == 4'b1111) begin
              if (deb_next == DEB_LAST) begin
                state   <= SCAN;
                deb_cnt <= '0;
                col     <= col_rot;
              end else begin
                deb_cnt <= deb_next;
              end
            end else begin
              deb_cnt <= '0;
            end
          end
          default: begin
            state   <= SCAN;
            deb_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_bcd_entry.sv
// Testbench for keypad_bcd_entry: models the keypad matrix and the number
// being typed (as a plain decimal value), compares every cycle.
`timescale 1ns/1ps
module tb_keypad_bcd_entry;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic checking = 1'b0;

  int n_compared = 0;
  int n_mismatched = 0;
  int kv_count = 0;

  logic [3:0][3:0] key_held = '0;
  logic [3:0] exp_q[$];
  int model_value = 0;
  logic [3:0] last_code = 4'h0;
  logic [3:0] key_map [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  keypad_bcd_entry_if bus();

  keypad_bcd_entry #(
    .SCAN_DIV    (4),
    .DEBOUNCE_CNT(3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a row reads low when a held key sits on the driven column.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      bus.row[r] = ~|(key_held[r] & ~bus.col);
    end
  end

  task automatic check_output(input string name, input int actual, input int expected);
    n_compared++;
    if (actual != expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [15:0] model_digits();
    logic [15:0] d;
    d[3:0]   = 4'(model_value % 10);
    d[7:4]   = 4'((model_value / 10) % 10);
    d[11:8]  = 4'((model_value / 100) % 10);
    d[15:12] = 4'((model_value / 1000) % 10);
    return d;
  endfunction

  function automatic void model_apply(input logic [3:0] code);
    last_code = code;
    if (code <= 4'd9) model_value = (model_value * 10 + int'(code)) % 10000;
    else if (code == 4'hE) model_value = 0;
    else if (code == 4'hF) model_value = model_value / 10;
  endfunction

  // Per-cycle compare against the keypad/number model, away from the clock edge.
  always @(negedge clk) begin
    if (checking) begin
      if (bus.key_valid) begin
        kv_count++;
        if (exp_q.size() == 0) begin
          check_output("unexpected_key_valid", int'(bus.key_valid), 0);
        end else begin
          logic [3:0] code;
          code = exp_q.pop_front();
          check_output("key_code_on_valid", int'(bus.key_code), int'(code));
          model_apply(code);
        end
      end
      check_output("digits", int'({bus.mil, bus.cen, bus.dec, bus.uni}), int'(model_digits()));
      check_output("key_code", int'(bus.key_code), int'(last_code));
      check_output("col_one_low", $countones(~bus.col), 1);
    end
  end

  task automatic wait_accept(input int start);
    int n = 0;
    while (kv_count == start && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (kv_count == start) check_output("accept_timeout", kv_count, start + 1);
  endtask

  task automatic apply_stimulus(input int r, input int c);
    int start;
    start = kv_count;
    exp_q.push_back(key_map[r][c]);
    key_held[r][c] = 1'b1;
    wait_accept(start);
    key_held[r][c] = 1'b0;
    repeat (40) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_value = 0;
    last_code = 4'h0;
    exp_q.delete();
  endtask

  task automatic check_digits(input string name, input logic [15:0] expected);
    check_output(name, int'({bus.mil, bus.cen, bus.dec, bus.uni}), int'(expected));
  endtask

  initial begin
    int start;
    int n;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checking = 1'b1;
    check_output("reset_col", int'(bus.col), int'(4'b1110));
    check_digits("reset_digits", 16'h0000);
    check_output("reset_key_code", int'(bus.key_code), 0);
    check_output("reset_key_valid", int'(bus.key_valid), 0);

    // Hold '5' steadily: exactly one accept.
    $display("[TB] hold 5");
    start = kv_count;
    exp_q.push_back(4'h5);
    key_held[1][1] = 1'b1;
    wait_accept(start);
    repeat (300) @(posedge clk);
    #1;
    check_output("hold_single_accept", kv_count - start, 1);
    check_digits("hold_digits", 16'h0005);
    check_output("hold_key_code", int'(bus.key_code), 5);
    key_held[1][1] = 1'b0;
    repeat (40) @(posedge clk);
    #1;

    // Clear, then type 1 2 3 4 7.
    $display("[TB] digit entry");
    apply_stimulus(3, 0);
    check_digits("clear_digits", 16'h0000);
    apply_stimulus(0, 0);
    apply_stimulus(0, 1);
    apply_stimulus(0, 2);
    apply_stimulus(1, 0);
    check_digits("after_1234", 16'h1234);
    apply_stimulus(2, 0);
    check_digits("after_7", 16'h2347);

    // Clear, 1 2 3, backspace, clear.
    $display("[TB] backspace and clear");
    apply_stimulus(3, 0);
    apply_stimulus(0, 0);
    apply_stimulus(0, 1);
    apply_stimulus(0, 2);
    check_digits("after_123", 16'h0123);
    apply_stimulus(3, 2);
    check_digits("after_hash", 16'h0012);
    check_output("hash_code", int'(bus.key_code), 15);
    apply_stimulus(3, 0);
    check_digits("after_star", 16'h0000);
    check_output("star_code", int'(bus.key_code), 14);

    // Bouncing '5': never stable for three ticks.
    $display("[TB] bounce");
    start = kv_count;
    repeat (8) begin
      key_held[1][1] = 1'b1;
      repeat (6) @(posedge clk);
      key_held[1][1] = 1'b0;
      repeat (6) @(posedge clk);
    end
    repeat (20) @(posedge clk);
    #1;
    check_output("bounce_no_accept", kv_count - start, 0);
    apply_stimulus(1, 1);
    check_digits("bounce_then_stable", 16'h0005);

    // Two keys in one column: rejected. Then 'A' alone.
    $display("[TB] two keys");
    start = kv_count;
    key_held[0][0] = 1'b1;
    key_held[1][0] = 1'b1;
    repeat (100) @(posedge clk);
    key_held[0][0] = 1'b0;
    key_held[1][0] = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check_output("two_keys_no_accept", kv_count - start, 0);
    apply_stimulus(0, 3);
    check_output("a_code", int'(bus.key_code), 10);
    check_digits("a_digits", 16'h0005);

    // Reset in the middle of debouncing '8'.
    $display("[TB] reset mid-debounce");
    start = kv_count;
    key_held[2][1] = 1'b1;
    n = 0;
    while (bus.col != 4'b1101 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (bus.col != 4'b1101) check_output("col1_timeout", int'(bus.col), int'(4'b1101));
    repeat (6) @(posedge clk);
    #1 key_held[2][1] = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_value = 0;
    last_code = 4'h0;
    exp_q.delete();
    check_output("mid_reset_col", int'(bus.col), int'(4'b1110));
    check_digits("mid_reset_digits", 16'h0000);
    check_output("mid_reset_key_valid", int'(bus.key_valid), 0);
    repeat (60) @(posedge clk);
    #1;
    check_output("mid_reset_no_accept", kv_count - start, 0);
    apply_stimulus(2, 2);
    check_digits("resume_digits", 16'h0009);

    do_reset();
    check_digits("final_reset_digits", 16'h0000);
    check_output("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
